any1_vagen: RTL and testbench
=============================

// Module: any1_vagen
// PURPOSE
//  Multi-beat address generator for ANY-1 scalar, strided, unit-stride and indexed loads/stores.
//  Accepts one memory-op request and emits a stream of effective addresses, one per element,
//  over a valid/ready handshake to the memory queue.
//  Sits between the register-read stage and the LSU. The per-element step count is internal,
//  so the caller supplies no step input.
// PARAMETERS
//  AWID   32  effective-address width in bits
//  LW     6   element-count width; vl range 0..2**LW-1
//  SCW    3   shift-scale field width
// PORTS
//  clk        in   1     clock
//  rst        in   1     reset, synchronous, active-high
//  req_valid  in   1     request present
//  req_ready  out  1     block idle; a request is accepted on req_valid&req_ready
//  req_mode   in   2     00 SCALAR, 01 STRIDE, 10 INDEX, 11 UNIT
//  req_base   in   AWID  base register value (ia)
//  req_imm    in   AWID  displacement
//  req_xs     in   AWID  SCALAR: index; STRIDE: stride; otherwise ignored
//  req_sc     in   SCW   index/element shift amount
//  req_vl     in   LW    element count (ignored in SCALAR)
//  idx_valid  in   1     INDEX-mode element index present
//  idx_ready  out  1     index consumed on idx_valid&idx_ready
//  idx_data   in   AWID  per-element index
//  abort      in   1     flush the current sequence
//  ea_valid   out  1     ea holds a valid address
//  ea_ready   in   1     consumer accepts ea on ea_valid&ea_ready
//  ea         out  AWID  effective address
//  ea_step    out  LW    element number of the current beat
//  ea_last    out  1     final beat of the sequence
//  ea_fault   out  1     bounds fault on this beat
//  lim_lo     in   AWID  lower bound, inclusive (used only with ANY1_VAGEN_BOUNDS_EN)
//  lim_hi     in   AWID  upper bound, inclusive (used only with ANY1_VAGEN_BOUNDS_EN)
//  done       out  1     one-cycle pulse when a sequence completes normally
// BEHAVIOUR
//  Reset: state IDLE. req_ready=1 in IDLE. All other outputs 0: ea, ea_valid, ea_step,
//   ea_last, ea_fault, idx_ready, done. Internal accumulator and counters cleared.
//  States and transitions:
//   IDLE -> RUN on accept. RUN -> IDLE when the last beat is accepted, or on abort.
//   req_ready=(state==IDLE).
//  Address arithmetic: all sums are modulo 2**AWID; carries are discarded.
//   SCALAR: single beat, ea=imm+base+(xs<<sc).
//   STRIDE: ea(k)=imm+base+k*xs. Built with an accumulator: acc=imm+base at accept,
//    then acc+=xs per accepted beat. No multiplier.
//   UNIT: as STRIDE with stride=1<<sc.
//   INDEX: ea(k)=imm+base+(idx_data<<sc). imm+base is latched at accept.
//  Latency:
//   SCALAR/STRIDE/UNIT: accept at cycle T -> first ea_valid at T+1.
//   INDEX: ea_valid one cycle after the idx handshake.
//  Throughput: 1 beat/cycle with ea_ready held high.
//  Output register: ea, ea_step, ea_last and ea_fault stay stable while ea_valid&!ea_ready.
//   The next beat loads in the same cycle the current beat is accepted (no bubble).
//  Index handshake: idx_ready=(state==RUN)&&INDEX&&elements remain&&(!ea_valid||ea_ready).
//  Beat tagging: ea_step counts 0..vl-1. ea_last=1 on beat vl-1 (on the single SCALAR beat).
//  vl==0 in a vector mode: no beats; done pulses at T+1; return to IDLE at T+1.
//  done pulses the cycle after the last beat is accepted.
//  abort (any state): ea_valid=0 and IDLE on the next cycle; no done pulse.
//   abort wins over a simultaneous req or ea handshake; that beat is treated as not issued.
//  Requests arriving while RUN wait (req_ready=0); no queueing.
//  rst mid-sequence: identical to reset; no done pulse.
// CONFIGURATION
//  ANY1_VAGEN_BOUNDS_EN defined:
//   Each generated ea is compared with lim_lo/lim_hi (inclusive, unsigned).
//   On an out-of-range beat: ea_fault=1 and ea_last=1 on that beat; the sequence
//    terminates after it is accepted.
//   done pulses; remaining idx inputs are not consumed.
//  ANY1_VAGEN_BOUNDS_EN undefined:
//   lim_lo/lim_hi ignored; ea_fault tied 0.
//  Ports are present in both builds for uniform wiring.
// TESTING
//  1 SCALAR: base=0x1000, imm=0x10, xs=3, sc=3 -> one beat ea=0x1028, ea_last=1, done at T+2.
//  2 STRIDE: base=0x2000, imm=0, xs=0x40, vl=4, ea_ready=1
//     -> ea=0x2000,0x2040,0x2080,0x20C0 on T+1..T+4, steps 0..3, last on step 3.
//  3 Backpressure: test 2 with ea_ready low on beat 1 for 3 cycles
//     -> ea=0x2040 held stable; no beat lost or duplicated.
//  4 INDEX: sc=2, idx=5,0,7, base=0x100 -> ea=0x114,0x100,0x11C; vl=0 -> no beats, done at T+1.
//  5 Wrap/abort: AWID=32, base=0xFFFFFFF0, stride=0x20, vl=2 -> 0xFFFFFFF0, 0x00000010.
//     abort after beat 0 -> ea_valid=0 next cycle, no done, req_ready=1.
//  6 BOUNDS_EN: lim=0x2000..0x207F with test 2 -> beat 2 (0x2080) ea_fault=1, ea_last=1;
//     done pulses; no beat 3.

Source files
------------

// File: rtl/any1_vagen_if.sv
// any1_vagen_if: request, index, address-stream and bounds signals of the vector address generator.
interface any1_vagen_if #(
    parameter int AWID = 32,
    parameter int LW   = 6,
    parameter int SCW  = 3
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_mode;
    logic [AWID-1:0] req_base;
    logic [AWID-1:0] req_imm;
    logic [AWID-1:0] req_xs;
    logic [SCW-1:0]  req_sc;
    logic [LW-1:0]   req_vl;
    logic            idx_valid;
    logic            idx_ready;
    logic [AWID-1:0] idx_data;
    logic            abort;
    logic            ea_valid;
    logic            ea_ready;
    logic [AWID-1:0] ea;
    logic [LW-1:0]   ea_step;
    logic            ea_last;
    logic            ea_fault;
    logic [AWID-1:0] lim_lo;
    logic [AWID-1:0] lim_hi;
    logic            done;

    modport master (
        output req_valid, req_mode, req_base, req_imm, req_xs, req_sc, req_vl,
               idx_valid, idx_data, abort, ea_ready, lim_lo, lim_hi,
        input  req_ready, idx_ready, ea_valid, ea, ea_step, ea_last, ea_fault, done
    );

    modport slave (
        input  req_valid, req_mode, req_base, req_imm, req_xs, req_sc, req_vl,
               idx_valid, idx_data, abort, ea_ready, lim_lo, lim_hi,
        output req_ready, idx_ready, ea_valid, ea, ea_step, ea_last, ea_fault, done
    );
endinterface

// File: rtl/any1_vagen.sv
// any1_vagen: per-element effective-address generator for scalar/strided/unit/indexed memory ops.
// Define ANY1_VAGEN_BOUNDS_EN to check each address against lim_lo..lim_hi and end the sequence on a fault.
module any1_vagen #(
    parameter int AWID = 32,
    parameter int LW   = 6,
    parameter int SCW  = 3
) (
    input logic        clk,
    input logic        rst,
    any1_vagen_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [1:0] M_SCALAR = 2'b00;
    localparam logic [1:0] M_INDEX  = 2'b10;
    localparam logic [1:0] M_UNIT   = 2'b11;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [AWID-1:0] acc_q, acc_d, stride_q, stride_d, ea_q, ea_d;
    logic [SCW-1:0]  sc_q, sc_d;
    logic [LW-1:0]   vl_q, vl_d, cnt_q, cnt_d, step_q, step_d;
    logic            valid_q, valid_d, last_q, last_d, fault_q, fault_d, done_q, done_d;

    logic [AWID-1:0] base_sum, req_stride, load_addr;
    logic [LW-1:0]   load_step, load_vl;
    logic            req_index, req_scalar, empty, accept, load_acc, is_index;
    logic            more, slot_free, load_run, load, fin, oob;

    assign base_sum   = bus.req_imm + bus.req_base;
    assign req_index  = bus.req_mode == M_INDEX;
    assign req_scalar = bus.req_mode == M_SCALAR;
    assign req_stride = bus.req_mode == M_UNIT ? AWID'(1) << bus.req_sc : bus.req_xs;
    assign empty      = !req_scalar && bus.req_vl == '0;
    assign accept     = bus.req_valid && state_q == IDLE && !bus.abort;
    assign load_acc   = accept && !req_index && !empty;
    assign is_index   = mode_q == M_INDEX;
    // A held last beat (normal or faulting) blocks any further element
    assign more       = state_q == RUN && cnt_q < vl_q && !(valid_q && last_q);
    assign slot_free  = !valid_q || bus.ea_ready;
    assign load_run   = more && slot_free && (!is_index || bus.idx_valid) && !bus.abort;
    assign load       = load_acc || load_run;
    assign fin        = valid_q && bus.ea_ready && last_q && !bus.abort;
    assign load_addr  = load_acc ? (req_scalar ? base_sum + (bus.req_xs << bus.req_sc) : base_sum)
                                 : (is_index ? acc_q + (bus.idx_data << sc_q) : acc_q);
    assign load_step  = load_acc ? '0 : cnt_q;
    assign load_vl    = load_acc ? (req_scalar ? LW'(1) : bus.req_vl) : vl_q;

`ifdef ANY1_VAGEN_BOUNDS_EN
    assign oob = load_addr < bus.lim_lo || load_addr > bus.lim_hi;
`else
    logic unused_lim;
    assign unused_lim = ^{bus.lim_lo, bus.lim_hi};
    assign oob = 1'b0;
`endif

    assign bus.req_ready = state_q == IDLE;
    assign bus.idx_ready = more && is_index && slot_free && !bus.abort;
    assign bus.ea_valid  = valid_q;
    assign bus.ea        = ea_q;
    assign bus.ea_step   = step_q;
    assign bus.ea_last   = last_q;
    assign bus.ea_fault  = fault_q;
    assign bus.done      = done_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        stride_d = stride_q;
        sc_d     = sc_q;
        vl_d     = vl_q;
        cnt_d    = cnt_q;
        ea_d     = ea_q;
        step_d   = step_q;
        last_d   = last_q;
        fault_d  = fault_q;
        valid_d  = valid_q && !bus.ea_ready;
        done_d   = 1'b0;
        if (accept) begin
            mode_d   = bus.req_mode;
            sc_d     = bus.req_sc;
            stride_d = req_stride;
            vl_d     = req_scalar ? LW'(1) : bus.req_vl;
            cnt_d    = '0;
            acc_d    = req_index ? base_sum : base_sum + req_stride;
            state_d  = empty ? IDLE : RUN;
            done_d   = empty;
        end
        if (fin) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        if (load) begin
            valid_d = 1'b1;
            ea_d    = load_addr;
            step_d  = load_step;
            last_d  = load_step == load_vl - LW'(1) || oob;
            fault_d = oob;
            cnt_d   = load_step + LW'(1);
        end
        if (load_run && !is_index) acc_d = acc_q + stride_q;
        if (bus.abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            acc_q    <= '0;
            stride_q <= '0;
            sc_q     <= '0;
            vl_q     <= '0;
            cnt_q    <= '0;
            ea_q     <= '0;
            step_q   <= '0;
            last_q   <= 1'b0;
            fault_q  <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            stride_q <= stride_d;
            sc_q     <= sc_d;
            vl_q     <= vl_d;
            cnt_q    <= cnt_d;
            ea_q     <= ea_d;
            step_q   <= step_d;
            last_q   <= last_d;
            fault_q  <= fault_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_any1_vagen.sv
// tb_any1_vagen: directed stimulus with a scoreboard of expected address beats.
module tb_any1_vagen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    any1_vagen_if #(.AWID(32), .LW(6), .SCW(3)) bus ();
    any1_vagen #(.AWID(32), .LW(6), .SCW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] ea;
        logic [5:0]  step;
        logic        last;
        logic        fault;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int d0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ea, input logic [5:0] step, input logic last, input logic fault);
        exp_q.push_back('{ea, step, last, fault});
    endtask

    always @(negedge clk) begin
        if (!rst && bus.ea_valid && bus.ea_ready && !bus.abort) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got ea=%h step=%0d expected no beat", bus.ea, bus.ea_step);
            end else begin
                e = exp_q.pop_front();
                check("beat_ea", 64'(bus.ea), 64'(e.ea));
                check("beat_step", 64'(bus.ea_step), 64'(e.step));
                check("beat_last", 64'(bus.ea_last), 64'(e.last));
                check("beat_fault", 64'(bus.ea_fault), 64'(e.fault));
            end
        end
        if (!rst && bus.done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] m, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] xs, input logic [2:0] sc, input logic [5:0] vl);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        bus.req_valid = 1'b1;
        bus.req_mode  = m;
        bus.req_base  = base;
        bus.req_imm   = imm;
        bus.req_xs    = xs;
        bus.req_sc    = sc;
        bus.req_vl    = vl;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic send_idx(input logic [31:0] v);
        int n = 0;
        bus.idx_valid = 1'b1;
        bus.idx_data  = v;
        while (!bus.idx_ready && n < 50) begin
            tick();
            n++;
        end
        check("idx_ready_seen", 64'(bus.idx_ready), 64'd1);
        tick();
        check("idx_latency_valid", 64'(bus.ea_valid), 64'd1);
        bus.idx_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        check(name, 64'(bus.done), 64'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_mode = 2'b00; bus.req_base = '0; bus.req_imm = '0;
        bus.req_xs = '0; bus.req_sc = '0; bus.req_vl = '0; bus.idx_valid = 1'b0; bus.idx_data = '0;
        bus.abort = 1'b0; bus.ea_ready = 1'b1; bus.lim_lo = 32'h0; bus.lim_hi = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_ea_valid", 64'(bus.ea_valid), 64'd0);
        check("rst_ea", 64'(bus.ea), 64'd0);
        check("rst_ea_step", 64'(bus.ea_step), 64'd0);
        check("rst_ea_last", 64'(bus.ea_last), 64'd0);
        check("rst_ea_fault", 64'(bus.ea_fault), 64'd0);
        check("rst_idx_ready", 64'(bus.idx_ready), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        tick();

        // 1 SCALAR
        push(32'h1028, 6'd0, 1'b1, 1'b0);
        issue(2'b00, 32'h1000, 32'h10, 32'd3, 3'd3, 6'd0);
        check("t1_valid_T1", 64'(bus.ea_valid), 64'd1);
        check("t1_busy", 64'(bus.req_ready), 64'd0);
        tick();
        check("t1_done_T2", 64'(bus.done), 64'd1);
        tick();
        check("t1_done_pulse", 64'(bus.done), 64'd0);
        check("t1_idle", 64'(bus.req_ready), 64'd1);

        // 2 STRIDE
        for (int k = 0; k < 4; k++) push(32'h2000 + 32'(k) * 32'h40, 6'(k), k == 3, 1'b0);
        issue(2'b01, 32'h2000, 32'h0, 32'h40, 3'd0, 6'd4);
        check("t2_valid_T1", 64'(bus.ea_valid), 64'd1);
        repeat (3) tick();
        check("t2_no_early_done", 64'(bus.done), 64'd0);
        tick();
        check("t2_done", 64'(bus.done), 64'd1);
        tick();

        // 3 Backpressure on beat 1
        for (int k = 0; k < 4; k++) push(32'h2000 + 32'(k) * 32'h40, 6'(k), k == 3, 1'b0);
        issue(2'b01, 32'h2000, 32'h0, 32'h40, 3'd0, 6'd4);
        check("t3_first_ea", 64'(bus.ea), 64'h2000);
        tick();
        bus.ea_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("t3_hold_ea", 64'(bus.ea), 64'h2040);
            check("t3_hold_valid", 64'(bus.ea_valid), 64'd1);
            tick();
        end
        check("t3_hold_step", 64'(bus.ea_step), 64'd1);
        bus.ea_ready = 1'b1;
        wait_done("t3_done");

        // 4 INDEX, then vl=0
        push(32'h114, 6'd0, 1'b0, 1'b0);
        push(32'h100, 6'd1, 1'b0, 1'b0);
        push(32'h11C, 6'd2, 1'b1, 1'b0);
        issue(2'b10, 32'h100, 32'h0, 32'h0, 3'd2, 6'd3);
        check("t4_no_beat_before_idx", 64'(bus.ea_valid), 64'd0);
        send_idx(32'd5);
        send_idx(32'd0);
        send_idx(32'd7);
        wait_done("t4_done");
        issue(2'b10, 32'h100, 32'h0, 32'h0, 3'd2, 6'd0);
        check("t4_vl0_done", 64'(bus.done), 64'd1);
        check("t4_vl0_idle", 64'(bus.req_ready), 64'd1);
        check("t4_vl0_no_beat", 64'(bus.ea_valid), 64'd0);
        tick();

        // 5 Wrap, then abort after beat 0
        push(32'hFFFF_FFF0, 6'd0, 1'b0, 1'b0);
        push(32'h0000_0010, 6'd1, 1'b1, 1'b0);
        issue(2'b01, 32'hFFFF_FFF0, 32'h0, 32'h20, 3'd0, 6'd2);
        wait_done("t5_wrap_done");
        tick();
        d0 = done_cnt;
        push(32'hFFFF_FFF0, 6'd0, 1'b0, 1'b0);
        issue(2'b01, 32'hFFFF_FFF0, 32'h0, 32'h20, 3'd0, 6'd4);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_abort_valid", 64'(bus.ea_valid), 64'd0);
        check("t5_abort_idle", 64'(bus.req_ready), 64'd1);
        check("t5_abort_no_done", 64'(bus.done), 64'd0);
        repeat (3) tick();
        check("t5_abort_done_count", 64'(done_cnt), 64'(d0));

        // 6 Bounds window 0x2000..0x207F
        bus.lim_lo = 32'h2000;
        bus.lim_hi = 32'h207F;
`ifdef ANY1_VAGEN_BOUNDS_EN
        push(32'h2000, 6'd0, 1'b0, 1'b0);
        push(32'h2040, 6'd1, 1'b0, 1'b0);
        push(32'h2080, 6'd2, 1'b1, 1'b1);
`else
        for (int k = 0; k < 4; k++) push(32'h2000 + 32'(k) * 32'h40, 6'(k), k == 3, 1'b0);
`endif
        issue(2'b01, 32'h2000, 32'h0, 32'h40, 3'd0, 6'd4);
        wait_done("t6_done");
        repeat (3) tick();
        check("t6_idle", 64'(bus.req_ready), 64'd1);
        bus.lim_lo = 32'h0;
        bus.lim_hi = 32'hFFFF_FFFF;

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
